// File: rtl/lim_inc_pkg.sv
// Shared types and helpers for the limited (modulo-L) incrementor.
package lim_inc_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic             co;
    logic [MAX_W-1:0] sum;
  } lim_res_t;

  // The compare runs one bit wider than the operand so a+ci never truncates.
  function automatic int cmp_w(input int n);
    return n + 1;
  endfunction

  function automatic lim_res_t lim_calc(input logic [MAX_W-1:0] a,
                                        input logic             ci,
                                        input logic [MAX_W-1:0] l);
    lim_res_t         r;
    logic [MAX_W-1:0] t;
    t = a + MAX_W'(ci);
    if (t >= l) begin
      r.sum = '0;
      r.co  = 1'b1;
    end else begin
      r.sum = t;
      r.co  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/lim_inc_core.sv
// Combinational add / compare / wrap for one limited-increment stage.
module lim_inc_core
  import lim_inc_pkg::*;
#(
  parameter int N = 4,
  parameter int L = 10
) (
  input  logic [N-1:0] a,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  localparam int W = cmp_w(N);

  // N is capped so 2^N still fits the int-typed limit.
  if (N < 1 || N > 30) begin : g_bad_n
    $error("lim_inc_core: N=%0d outside 1..30", N);
  end
  if (L < 1 || longint'(L) > (longint'(1) << (W-1))) begin : g_bad_l
    $error("lim_inc_core: L=%0d outside 1..2^N", L);
  end

  lim_res_t res;
  logic     unused_hi;

  always_comb begin
    res = lim_calc(MAX_W'(a), ci, MAX_W'(L));
  end

  assign sum       = res.sum[N-1:0];
  assign co        = res.co;
  assign unused_hi = ^res.sum[MAX_W-1:N];

endmodule

// File: rtl/lim_inc.sv
// Limited incrementor with registered output stage.
// Optional LIM_INC_STICKY_EN adds wrap_seen, a sticky flag of any enabled wrap.
module lim_inc
  import lim_inc_pkg::*;
#(
  parameter int N = 4,
  parameter int L = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic         ci,
  input  logic         en,
  output logic [N-1:0] sum,
  output logic         co,
  output logic [N-1:0] sum_q,
`ifdef LIM_INC_STICKY_EN
  output logic         wrap_seen,
`endif
  output logic         co_q
);

  lim_inc_core #(.N(N), .L(L)) u_core (
    .a   (a),
    .ci  (ci),
    .sum (sum),
    .co  (co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else if (en) begin
      sum_q <= sum;
      co_q  <= co;
    end
  end

`ifdef LIM_INC_STICKY_EN
  // Only rst clears it; later non-wrap loads leave it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wrap_seen <= 1'b0;
    else if (en && co)
      wrap_seen <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_lim_inc.sv
// Directed self-checking bench for lim_inc (N=4, L=7 plus an L=16 instance).
module tb_lim_inc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic       ci;
  logic       en;
  logic [3:0] sum, sum_q, sum16, sum_q16;
  logic       co, co_q, co16, co_q16;
`ifdef LIM_INC_STICKY_EN
  logic       wrap_seen, wrap_seen16;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lim_inc #(.N(4), .L(7)) dut (
    .clk(clk), .rst(rst), .a(a), .ci(ci), .en(en),
    .sum(sum), .co(co), .sum_q(sum_q),
`ifdef LIM_INC_STICKY_EN
    .wrap_seen(wrap_seen),
`endif
    .co_q(co_q)
  );

  lim_inc #(.N(4), .L(16)) dut16 (
    .clk(clk), .rst(rst), .a(a), .ci(ci), .en(en),
    .sum(sum16), .co(co16), .sum_q(sum_q16),
`ifdef LIM_INC_STICKY_EN
    .wrap_seen(wrap_seen16),
`endif
    .co_q(co_q16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance through one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst = 1'b1; a = '0; ci = 1'b0; en = 1'b0;
    #3;
    chk("reset sum_q", 32'(sum_q), 0);
    chk("reset co_q", 32'(co_q), 0);
`ifdef LIM_INC_STICKY_EN
    chk("reset wrap_seen", 32'(wrap_seen), 0);
`endif

    // Combinational sweep with rst held: reset must not touch sum/co.
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2; c++) begin
        a = 4'(i); ci = 1'(c);
        #10;
        t = i + c;
        chk($sformatf("sweep sum a=%0d ci=%0d", i, c), 32'(sum), (t >= 7) ? 0 : t);
        chk($sformatf("sweep co a=%0d ci=%0d", i, c), 32'(co), (t >= 7) ? 1 : 0);
      end
    end

    a = 4'd5; ci = 1'b1; #10;
    chk("spot 5+1 sum", 32'(sum), 6);
    chk("spot 5+1 co", 32'(co), 0);
    a = 4'd6; ci = 1'b1; #10;
    chk("spot 6+1 sum", 32'(sum), 0);
    chk("spot 6+1 co", 32'(co), 1);
    a = 4'd6; ci = 1'b0; #10;
    chk("spot 6+0 sum", 32'(sum), 6);
    chk("spot 6+0 co", 32'(co), 0);
    a = 4'd9; ci = 1'b0; #10;
    chk("over 9+0 sum", 32'(sum), 0);
    chk("over 9+0 co", 32'(co), 1);

    // L = 2^N behaves as a plain 4-bit incrementor.
    a = 4'd15; ci = 1'b1; #10;
    chk("L16 15+1 sum", 32'(sum16), 0);
    chk("L16 15+1 co", 32'(co16), 1);
    a = 4'd15; ci = 1'b0; #10;
    chk("L16 15+0 sum", 32'(sum16), 15);
    chk("L16 15+0 co", 32'(co16), 0);
    a = 4'd14; ci = 1'b1; #10;
    chk("L16 14+1 sum", 32'(sum16), 15);
    chk("L16 14+1 co", 32'(co16), 0);

    // Reset dominates en across an edge.
    a = 4'd3; ci = 1'b1; en = 1'b1;
    tick();
    chk("rst held sum_q", 32'(sum_q), 0);
    chk("rst held co_q", 32'(co_q), 0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("load 3+1 sum_q", 32'(sum_q), 4);
    chk("load 3+1 co_q", 32'(co_q), 0);
`ifdef LIM_INC_STICKY_EN
    chk("no wrap wrap_seen", 32'(wrap_seen), 0);
`endif

    @(negedge clk);
    en = 1'b0; a = 4'd6; ci = 1'b1;
    tick();
    chk("hold sum_q", 32'(sum_q), 4);
    chk("hold co_q", 32'(co_q), 0);
`ifdef LIM_INC_STICKY_EN
    chk("hold wrap_seen", 32'(wrap_seen), 0);
`endif

    // Mid-cycle async reset, no clock edge involved.
    #2;
    rst = 1'b1;
    #1;
    chk("async rst sum_q", 32'(sum_q), 0);
    chk("async rst co_q", 32'(co_q), 0);

    @(negedge clk);
    rst = 1'b0; a = 4'd6; ci = 1'b1; en = 1'b1;
    tick();
    chk("wrap load sum_q", 32'(sum_q), 0);
    chk("wrap load co_q", 32'(co_q), 1);
    chk("L16 6+1 sum_q", 32'(sum_q16), 7);
`ifdef LIM_INC_STICKY_EN
    chk("wrap sets wrap_seen", 32'(wrap_seen), 1);
    chk("L16 wrap_seen clear", 32'(wrap_seen16), 0);
`endif

    @(negedge clk);
    a = 4'd1; ci = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-wrap sum_q %0d", k), 32'(sum_q), 1);
      chk($sformatf("post-wrap co_q %0d", k), 32'(co_q), 0);
`ifdef LIM_INC_STICKY_EN
      chk($sformatf("sticky %0d", k), 32'(wrap_seen), 1);
`endif
    end

    #2;
    rst = 1'b1;
    #1;
    chk("final rst sum_q", 32'(sum_q), 0);
`ifdef LIM_INC_STICKY_EN
    chk("rst clears wrap_seen", 32'(wrap_seen), 0);
`endif
    chk("comb under rst sum", 32'(sum), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
